mult_issue_arb: RTL

MULT_ISSUE_ARB -- requirements
Module: mult_issue_arb

---
 rtl/mult_issue_arb.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mult_issue_arb.sv
`default_nettype none
// ============================================================================
// Module   : mult_issue_arb (+ config_pkg)
// Brief    : Round-robin multi-thread issue stage and writeback demux for the
//            shared multiply/divide unit, with per-thread outstanding limits.
// Revision : 1.0
// ============================================================================

package config_pkg;

   typedef struct packed {
      int unsigned XLEN;
      int unsigned TRANS_ID_BITS;
      int unsigned THREAD_NUM;
   } cva6_cfg_t;

   localparam int unsigned CFG_XLEN          = 64;
   localparam int unsigned CFG_TRANS_ID_BITS = 3;
   localparam int unsigned CFG_THREAD_NUM    = 2;

   localparam cva6_cfg_t cva6_cfg_empty = '{
      XLEN:          CFG_XLEN,
      TRANS_ID_BITS: CFG_TRANS_ID_BITS,
      THREAD_NUM:    CFG_THREAD_NUM
   };

   function automatic int unsigned thread_id_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [7:0] fu_op_t;

   localparam fu_op_t OP_ADD    = 8'h00;
   localparam fu_op_t OP_SUB    = 8'h01;
   localparam fu_op_t OP_MUL    = 8'h10;
   localparam fu_op_t OP_MULH   = 8'h11;
   localparam fu_op_t OP_MULHU  = 8'h12;
   localparam fu_op_t OP_MULHSU = 8'h13;
   localparam fu_op_t OP_MULW   = 8'h14;
   localparam fu_op_t OP_CLMUL  = 8'h15;
   localparam fu_op_t OP_CLMULH = 8'h16;
   localparam fu_op_t OP_CLMULR = 8'h17;
   localparam fu_op_t OP_DIV    = 8'h20;
   localparam fu_op_t OP_DIVU   = 8'h21;
   localparam fu_op_t OP_DIVW   = 8'h22;
   localparam fu_op_t OP_DIVUW  = 8'h23;
   localparam fu_op_t OP_REM    = 8'h24;
   localparam fu_op_t OP_REMU   = 8'h25;
   localparam fu_op_t OP_REMW   = 8'h26;
   localparam fu_op_t OP_REMUW  = 8'h27;

   typedef struct packed {
      fu_op_t                                       operation;
      logic [CFG_XLEN-1:0]                          operand_a;
      logic [CFG_XLEN-1:0]                          operand_b;
      logic [CFG_TRANS_ID_BITS-1:0]                 trans_id;
      logic [thread_id_bits(CFG_THREAD_NUM)-1:0]    thread_id;
   } fu_data_t;

endpackage

module mult_issue_arb
   import config_pkg::*;
#(
   parameter cva6_cfg_t   CVA6Cfg   = cva6_cfg_empty,
   parameter type         fu_data_t = config_pkg::fu_data_t,
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic                                               clk_i,
   input  logic                                               rst_ni,
   input  logic                                               flush_i,
   input  logic [CVA6Cfg.THREAD_NUM-1:0]                      req_valid_i,
   input  fu_data_t                                           req_data_i [CVA6Cfg.THREAD_NUM],
   output logic [CVA6Cfg.THREAD_NUM-1:0]                      req_ready_o,
   output fu_data_t                                           fu_data_o,
   output logic                                               fu_valid_o,
   input  logic                                               mult_ready_i,
   input  logic                                               mult_valid_i,
   input  logic [CVA6Cfg.XLEN-1:0]                            mult_result_i,
   input  logic [CVA6Cfg.TRANS_ID_BITS-1:0]                   mult_trans_id_i,
   input  logic [thread_id_bits(CVA6Cfg.THREAD_NUM)-1:0]      mult_thread_id_i,
   output logic [CVA6Cfg.THREAD_NUM-1:0]                      wb_valid_o,
   output logic [CVA6Cfg.XLEN-1:0]                            wb_result_o,
   output logic [CVA6Cfg.TRANS_ID_BITS-1:0]                   wb_trans_id_o
);

   localparam int         c_threads = int'(CVA6Cfg.THREAD_NUM);
   localparam int         c_tid_w   = int'(thread_id_bits(CVA6Cfg.THREAD_NUM));
   localparam logic [3:0] c_max_cnt = 4'(MAX_OUTST);

   function automatic logic op_is_mul(input fu_op_t op);
      case (op)
         OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU,
         OP_MULW, OP_CLMUL, OP_CLMULH, OP_CLMULR: return 1'b1;
         default:                                 return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_div(input fu_op_t op);
      case (op)
         OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW,
         OP_REM, OP_REMU, OP_REMW, OP_REMUW: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   logic                                 valid_q, valid_d;
   logic                                 is_div_q, is_div_d;
   fu_data_t                             data_q, data_d;
   logic [c_tid_w-1:0]                   rr_q, rr_d;
   logic [3:0]                           cnt_q [c_threads];
   logic [3:0]                           cnt_d [c_threads];
   logic [c_threads-1:0]                 wb_valid_q, wb_valid_d;
   logic [CVA6Cfg.XLEN-1:0]              wb_result_q, wb_result_d;
   logic [CVA6Cfg.TRANS_ID_BITS-1:0]     wb_trans_id_q, wb_trans_id_d;

   logic                                 w_issue_done, w_loadable, w_grant, w_tid_ok;
   logic                                 w_found, w_found_hi;
   logic [c_threads-1:0]                 w_elig, w_req_div, w_inc, w_dec;
   logic [c_tid_w-1:0]                   w_first, w_first_hi, w_winner;

   assign w_issue_done = valid_q & (~is_div_q | mult_ready_i);
   assign w_loadable   = ~valid_q | w_issue_done;
   assign w_tid_ok     = (int'(mult_thread_id_i) < c_threads);

   always_comb begin : p_eligible
      w_elig    = '0;
      w_req_div = '0;
      for (int t = 0; t < c_threads; t++) begin
         w_req_div[t] = op_is_div(req_data_i[t].operation);
         w_elig[t]    = req_valid_i[t]
                      & (op_is_mul(req_data_i[t].operation) | w_req_div[t])
                      & (cnt_q[t] < c_max_cnt);
      end
   end

   // Descending scan leaves the lowest eligible index overall and the lowest
   // at/after rr_q; the latter wins, otherwise the search wraps around.
   always_comb begin : p_arbiter
      w_found    = 1'b0;
      w_found_hi = 1'b0;
      w_first    = '0;
      w_first_hi = '0;
      for (int t = c_threads - 1; t >= 0; t--) begin
         if (w_elig[t]) begin
            w_found = 1'b1;
            w_first = c_tid_w'(t);
            if (c_tid_w'(t) >= rr_q) begin
               w_found_hi = 1'b1;
               w_first_hi = c_tid_w'(t);
            end
         end
      end
      w_winner = w_found_hi ? w_first_hi : w_first;
   end

   assign w_grant = w_found & w_loadable & ~flush_i & rst_ni;

   always_comb begin : p_ready
      req_ready_o = '0;
      w_inc       = '0;
      w_dec       = '0;
      for (int t = 0; t < c_threads; t++) begin
         w_inc[t] = w_grant & (w_winner == c_tid_w'(t));
         w_dec[t] = mult_valid_i & w_tid_ok & (mult_thread_id_i == c_tid_w'(t));
      end
      req_ready_o = w_inc;
   end

   always_comb begin : p_next
      valid_d       = valid_q;
      is_div_d      = is_div_q;
      data_d        = data_q;
      rr_d          = rr_q;
      wb_valid_d    = w_dec;
      wb_result_d   = wb_result_q;
      wb_trans_id_d = wb_trans_id_q;

      if (flush_i) begin
         valid_d = 1'b0;
      end else if (w_grant) begin
         valid_d          = 1'b1;
         is_div_d         = w_req_div[w_winner];
         data_d           = req_data_i[w_winner];
         data_d.thread_id = w_winner;
         rr_d             = (w_winner == c_tid_w'(c_threads - 1)) ? '0
                                                                  : w_winner + c_tid_w'(1);
      end else if (w_issue_done) begin
         valid_d = 1'b0;
      end

      // Late results after a flush are still forwarded; the consumer drops
      // them by trans_id, and the counters simply saturate at zero.
      if (mult_valid_i) begin
         wb_result_d   = mult_result_i;
         wb_trans_id_d = mult_trans_id_i;
      end

      for (int t = 0; t < c_threads; t++) begin
         cnt_d[t] = cnt_q[t];
         if (flush_i) begin
            cnt_d[t] = '0;
         end else if (w_inc[t] && !w_dec[t]) begin
            cnt_d[t] = cnt_q[t] + 4'd1;
         end else if (w_dec[t] && !w_inc[t] && (cnt_q[t] != 4'd0)) begin
            cnt_d[t] = cnt_q[t] - 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin : p_regs
      if (!rst_ni) begin
         valid_q       <= 1'b0;
         is_div_q      <= 1'b0;
         data_q        <= '0;
         rr_q          <= '0;
         wb_valid_q    <= '0;
         wb_result_q   <= '0;
         wb_trans_id_q <= '0;
         for (int t = 0; t < c_threads; t++) begin
            cnt_q[t] <= '0;
         end
      end else begin
         valid_q       <= valid_d;
         is_div_q      <= is_div_d;
         data_q        <= data_d;
         rr_q          <= rr_d;
         wb_valid_q    <= wb_valid_d;
         wb_result_q   <= wb_result_d;
         wb_trans_id_q <= wb_trans_id_d;
         cnt_q         <= cnt_d;
      end
   end

   assign fu_valid_o    = valid_q;
   assign fu_data_o     = data_q;
   assign wb_valid_o    = wb_valid_q;
   assign wb_result_o   = wb_result_q;
   assign wb_trans_id_o = wb_trans_id_q;

endmodule
`default_nettype wire
